pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Pipeline sequencing controller between insDecode and execute.
//  Detects load-use hazards that forwarding cannot cover and holds the front end while a multi-cycle EX op (mult/div) runs.
//  Drives a per-stage stall vector and bubble-insert strobes to the pipeline registers.
//  Flush has the highest priority and aborts any stall in progress.
// PARAMETERS
//  CNT_W     6  width of ex_mc_len and of the internal busy counter
//  ZERO_REG  0  register index that never causes a hazard ($zero)
// PORTS
//  clk                 in   1      clock; all state updates on rising edge
//  rst                 in   1      synchronous, active-high reset
//  reg1_read_enabler   in   1      from insDecode: ID reads operand 1
//  reg1_addr_output    in   5      from insDecode: operand-1 register
//  reg2_read_enabler   in   1      from insDecode: ID reads operand 2
//  reg2_addr_output    in   5      from insDecode: operand-2 register
//  execute_WriteOrNot  in   1      EX instruction writes a register
//  execute_DestAddr    in   5      EX destination register
//  execute_IsLoad      in   1      EX instruction is a load (data available only after MEM)
//  flush               in   1      discard IF/ID/EX contents, abort stall
//  ex_mc_start         in   1      1-cycle pulse: EX begins a multi-cycle op
//  ex_mc_len           in   CNT_W  total EX occupancy of that op in cycles
//  stall               out  6      {wb,mem,ex,id,if,pc}; 1 = hold that stage register
//  id_bubble           out  1      load NOP into ID/EX register
//  mem_bubble          out  1      load NOP into EX/MEM register
//  ex_busy             out  1      multi-cycle op in progress
//  proto_err           out  1      sticky: ex_mc_start while busy
//  stall_cycles        out  32     stall statistics (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=RUN, cnt=0, proto_err=0, stall_cycles=0.
//   While rst=1, all outputs are forced to 0.
//  States: RUN, MC_BUSY. The state is registered; outputs are combinational from state and inputs.
//  Hazard (hz) = execute_IsLoad & execute_WriteOrNot & execute_DestAddr!=ZERO_REG &
//   ((reg1_read_enabler & reg1_addr_output==execute_DestAddr) | (reg2_read_enabler & reg2_addr_output==execute_DestAddr)).
//  Priority per cycle: rst > flush > MC_BUSY > ex_mc_start > hz > none.
//  flush:
//   - stall=0, bubbles=0 in that cycle.
//   - next state=RUN, cnt=0.
//   - A simultaneous ex_mc_start is dropped.
//  RUN, ex_mc_start, ex_mc_len>=2:
//   - stall=6'b001111, mem_bubble=1, ex_busy=1 in the start cycle.
//   - If ex_mc_len==2: stay RUN.
//   - Else: next=MC_BUSY, cnt=ex_mc_len-3.
//   - Net effect: the op holds EX for exactly ex_mc_len cycles, with ex_mc_len-1 stall cycles.
//  RUN, ex_mc_start, ex_mc_len 0 or 1: single-cycle op; no stall; the hazard check applies normally.
//  RUN, hz (no start): stall=6'b000111, id_bubble=1 for exactly one cycle. The load advances to MEM, and memory forwarding serves ID next cycle. No state change.
//  MC_BUSY:
//   - stall=6'b001111, mem_bubble=1, ex_busy=1.
//   - hz is ignored, because EX holds a non-load.
//   - cnt==0: next=RUN. Else cnt<=cnt-1.
//  ex_mc_start while MC_BUSY: ignored; proto_err<=1, which stays set until rst.
//  Combined bubbles: id_bubble and mem_bubble are never both 1. stall[5:4] is always 0, because MEM and WB always drain.
//  Reset mid-operation: state aborts to RUN at the next edge; no residual stall.
//  Max stall for ex_mc_len=2^CNT_W-1: 2^CNT_W-2 cycles. The counter never wraps.
// CONFIGURATION
//  STALL_STATS_EN defined:
//   - stall_cycles increments each cycle with stall!=0 and rst=0.
//   - It saturates at 32'hFFFF_FFFF and clears only on rst.
//  STALL_STATS_EN undefined: stall_cycles is tied to 0; no counter logic is generated.
// TESTING
//  1. EX lw $3; ID reads $3 via reg2 -> one cycle stall=000111, id_bubble=1; next cycle stall=0.
//  2. EX lw $0 (dest=0), ID reads $0 -> no stall; lw $3 with read_enabler=0 -> no stall.
//  3. ex_mc_start, len=5 -> stall=001111 for 4 consecutive cycles (start +3), ex_busy high 4 cycles, then 0.
//  4. len=5 started; flush in the 2nd cycle -> stall=0 that cycle and after; ex_busy=0 next cycle.
//  5. len=8 running; ex_mc_start again -> ignored, proto_err=1 until rst; op still ends after 7 stall cycles.
//  6. STALL_STATS_EN: scenario 1 then 3 -> stall_cycles=5; rst -> 0. Undefined: stall_cycles stays 0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/bubble sequencer between decode and execute: load-use hazards and multi-cycle EX ops.
// Optional macro STALL_STATS_EN enables the saturating stall_cycles counter.
module pipe_stall_ctrl #(
  parameter int          CNT_W    = 6,
  parameter logic [4:0]  ZERO_REG = 5'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg1_read_enabler,
  input  logic [4:0]       reg1_addr_output,
  input  logic             reg2_read_enabler,
  input  logic [4:0]       reg2_addr_output,
  input  logic             execute_WriteOrNot,
  input  logic [4:0]       execute_DestAddr,
  input  logic             execute_IsLoad,
  input  logic             flush,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_len,
  output logic [5:0]       stall,
  output logic             id_bubble,
  output logic             mem_bubble,
  output logic             ex_busy,
  output logic             proto_err,
  output logic [31:0]      stall_cycles
);

  typedef enum logic {RUN = 1'b0, MC_BUSY = 1'b1} state_t;

  localparam logic [5:0] STALL_MC = 6'b001111;
  localparam logic [5:0] STALL_HZ = 6'b000111;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             proto_err_q;
  logic             hz;
  logic             mc_go;

  // A load result only exists after MEM, so a matching ID read must wait one cycle.
  assign hz = execute_IsLoad & execute_WriteOrNot & (execute_DestAddr != ZERO_REG) &
              ((reg1_read_enabler & (reg1_addr_output == execute_DestAddr)) |
               (reg2_read_enabler & (reg2_addr_output == execute_DestAddr)));

  assign mc_go = ex_mc_start & (ex_mc_len >= CNT_W'(2));

  always_comb begin
    stall      = 6'b000000;
    id_bubble  = 1'b0;
    mem_bubble = 1'b0;
    ex_busy    = 1'b0;
    if (rst || flush) begin
      stall = 6'b000000;
    end else if (state == MC_BUSY || mc_go) begin
      stall      = STALL_MC;
      mem_bubble = 1'b1;
      ex_busy    = 1'b1;
    end else if (hz) begin
      stall     = STALL_HZ;
      id_bubble = 1'b1;
    end
  end

  // The start cycle covers one EX cycle and the ex_mc_len==2 case needs no busy state,
  // hence cnt is loaded with len-3 and MC_BUSY exits when it reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      proto_err_q <= 1'b0;
    end else if (flush) begin
      state <= RUN;
      cnt   <= '0;
    end else if (state == MC_BUSY) begin
      if (ex_mc_start) proto_err_q <= 1'b1;
      if (cnt == '0) state <= RUN;
      else           cnt   <= cnt - CNT_W'(1);
    end else if (mc_go && ex_mc_len != CNT_W'(2)) begin
      state <= MC_BUSY;
      cnt   <= ex_mc_len - CNT_W'(3);
    end
  end

  assign proto_err = proto_err_q & ~rst;

`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (stall != 6'b000000 && stall_cycles_q != 32'hFFFF_FFFF) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = rst ? 32'd0 : stall_cycles_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl; checks {stall,id_bubble,mem_bubble,ex_busy} per cycle.
module tb_pipe_stall_ctrl;

  localparam int CNT_W = 6;
  localparam logic [8:0] O_IDLE = 9'b000000_000;
  localparam logic [8:0] O_HZ   = 9'b000111_100;
  localparam logic [8:0] O_MC   = 9'b001111_011;

  logic             clk = 1'b0;
  logic             rst;
  logic             reg1_read_enabler;
  logic [4:0]       reg1_addr_output;
  logic             reg2_read_enabler;
  logic [4:0]       reg2_addr_output;
  logic             execute_WriteOrNot;
  logic [4:0]       execute_DestAddr;
  logic             execute_IsLoad;
  logic             flush;
  logic             ex_mc_start;
  logic [CNT_W-1:0] ex_mc_len;
  logic [5:0]       stall;
  logic             id_bubble;
  logic             mem_bubble;
  logic             ex_busy;
  logic             proto_err;
  logic [31:0]      stall_cycles;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] obs;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .ZERO_REG(5'd0)) dut (
    .clk(clk), .rst(rst),
    .reg1_read_enabler(reg1_read_enabler), .reg1_addr_output(reg1_addr_output),
    .reg2_read_enabler(reg2_read_enabler), .reg2_addr_output(reg2_addr_output),
    .execute_WriteOrNot(execute_WriteOrNot), .execute_DestAddr(execute_DestAddr),
    .execute_IsLoad(execute_IsLoad), .flush(flush),
    .ex_mc_start(ex_mc_start), .ex_mc_len(ex_mc_len),
    .stall(stall), .id_bubble(id_bubble), .mem_bubble(mem_bubble),
    .ex_busy(ex_busy), .proto_err(proto_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg1_read_enabler  = 1'b0; reg1_addr_output = 5'd0;
    reg2_read_enabler  = 1'b0; reg2_addr_output = 5'd0;
    execute_WriteOrNot = 1'b0; execute_DestAddr = 5'd0;
    execute_IsLoad     = 1'b0; flush = 1'b0;
    ex_mc_start        = 1'b0; ex_mc_len = '0;
  endtask

  task automatic set_load(input logic [4:0] dest);
    execute_IsLoad = 1'b1; execute_WriteOrNot = 1'b1; execute_DestAddr = dest;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    set_load(5'd3); reg2_read_enabler = 1'b1; reg2_addr_output = 5'd3;
    ex_mc_start = 1'b1; ex_mc_len = 6'd5;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL reset_forced: got %b want %b", obs, O_IDLE); end
    n_vec++;
    if ({proto_err, stall_cycles} !== 33'd0) begin
      n_err++; $display("FAIL reset_regs: got proto_err=%b stall_cycles=%0d want 0/0", proto_err, stall_cycles);
    end
    step(); step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL reset_release: got %b want %b", obs, O_IDLE); end
    step();
  endtask

  task automatic test_load_use();
    set_load(5'd3); reg2_read_enabler = 1'b1; reg2_addr_output = 5'd3;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_HZ) begin n_err++; $display("FAIL load_use_reg2: got %b want %b", obs, O_HZ); end
    step();
    idle();  // load moved to MEM; forwarding now covers it
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL load_use_after: got %b want %b", obs, O_IDLE); end
    step();
    set_load(5'd7); reg1_read_enabler = 1'b1; reg1_addr_output = 5'd7;
    reg2_read_enabler = 1'b1; reg2_addr_output = 5'd9;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_HZ) begin n_err++; $display("FAIL load_use_reg1: got %b want %b", obs, O_HZ); end
    step();
    idle();
  endtask

  task automatic test_no_hazard();
    set_load(5'd0); reg1_read_enabler = 1'b1; reg2_read_enabler = 1'b1;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL nohz_zero_reg: got %b want %b", obs, O_IDLE); end
    step();
    idle(); set_load(5'd3); reg2_addr_output = 5'd3; reg1_addr_output = 5'd3;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL nohz_no_read: got %b want %b", obs, O_IDLE); end
    step();
    reg2_read_enabler = 1'b1; execute_IsLoad = 1'b0;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL nohz_not_load: got %b want %b", obs, O_IDLE); end
    step();
    execute_IsLoad = 1'b1; execute_WriteOrNot = 1'b0;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL nohz_no_write: got %b want %b", obs, O_IDLE); end
    step();
    idle();
  endtask

  task automatic test_multicycle();
    ex_mc_start = 1'b1; ex_mc_len = 6'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs = {stall, id_bubble, mem_bubble, ex_busy};
      n_vec++;
      if (obs !== ((i < 4) ? O_MC : O_IDLE)) begin
        n_err++; $display("FAIL mc_len5_cyc%0d: got %b want %b", i, obs, (i < 4) ? O_MC : O_IDLE);
      end
      step();
      idle();
      // a matching load in EX during the busy window must not change the outputs
      if (i < 2) begin set_load(5'd4); reg1_read_enabler = 1'b1; reg1_addr_output = 5'd4; end
    end
    ex_mc_start = 1'b1; ex_mc_len = 6'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      obs = {stall, id_bubble, mem_bubble, ex_busy};
      n_vec++;
      if (obs !== ((i == 0) ? O_MC : O_IDLE)) begin
        n_err++; $display("FAIL mc_len2_cyc%0d: got %b want %b", i, obs, (i == 0) ? O_MC : O_IDLE);
      end
      step();
      idle();
    end
    ex_mc_start = 1'b1; ex_mc_len = 6'd1; set_load(5'd6); reg2_read_enabler = 1'b1; reg2_addr_output = 5'd6;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_HZ) begin n_err++; $display("FAIL mc_len1_hz: got %b want %b", obs, O_HZ); end
    step();
    idle(); ex_mc_start = 1'b1; ex_mc_len = 6'd0;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL mc_len0: got %b want %b", obs, O_IDLE); end
    step();
    idle();
  endtask

  task automatic test_max_len();
    int n;
    n = 0;
    ex_mc_start = 1'b1; ex_mc_len = 6'd63;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (stall !== 6'b001111) break;
      n++;
      step();
      ex_mc_start = 1'b0;
    end
    idle();
    n_vec++;
    if (n != 62) begin n_err++; $display("FAIL max_len_stalls: got %0d want 62", n); end
    step();
  endtask

  task automatic test_flush();
    ex_mc_start = 1'b1; ex_mc_len = 6'd5;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_MC) begin n_err++; $display("FAIL flush_start: got %b want %b", obs, O_MC); end
    step();
    idle(); flush = 1'b1;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL flush_cycle: got %b want %b", obs, O_IDLE); end
    step();
    idle();
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL flush_after: got %b want %b", obs, O_IDLE); end
    step();
    flush = 1'b1; ex_mc_start = 1'b1; ex_mc_len = 6'd5;
    set_load(5'd3); reg2_read_enabler = 1'b1; reg2_addr_output = 5'd3;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL flush_with_start: got %b want %b", obs, O_IDLE); end
    step();
    idle();
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if (obs !== O_IDLE) begin n_err++; $display("FAIL flush_start_dropped: got %b want %b", obs, O_IDLE); end
    step();
  endtask

  task automatic test_proto_err();
    int n;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      ex_mc_start = (i == 0 || i == 2);
      ex_mc_len   = (i == 0) ? 6'd8 : 6'd3;
      @(negedge clk);
      if (i == 2) begin
        n_vec++;
        if (proto_err !== 1'b0) begin n_err++; $display("FAIL proto_err_early: got %b want 0", proto_err); end
      end
      if (i == 3) begin
        n_vec++;
        if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_err_set: got %b want 1", proto_err); end
      end
      if (stall !== 6'b001111) break;
      n++;
      step();
    end
    idle();
    n_vec++;
    if (n != 7) begin n_err++; $display("FAIL proto_len8_stalls: got %0d want 7", n); end
    step(); step();
    n_vec++;
    if (proto_err !== 1'b1) begin n_err++; $display("FAIL proto_err_sticky: got %b want 1", proto_err); end
  endtask

  task automatic test_reset_mid_op();
    ex_mc_start = 1'b1; ex_mc_len = 6'd10;
    step();
    idle(); rst = 1'b1;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if ({obs, proto_err} !== {O_IDLE, 1'b0}) begin
      n_err++; $display("FAIL rst_mid_forced: got %b/%b want %b/0", obs, proto_err, O_IDLE);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    obs = {stall, id_bubble, mem_bubble, ex_busy};
    n_vec++;
    if ({obs, proto_err} !== {O_IDLE, 1'b0}) begin
      n_err++; $display("FAIL rst_mid_after: got %b/%b want %b/0", obs, proto_err, O_IDLE);
    end
    step();
  endtask

  task automatic test_stats();
    logic [31:0] want;
`ifdef STALL_STATS_EN
    want = 32'd5;
`else
    want = 32'd0;
`endif
    rst = 1'b1; idle();
    step();
    rst = 1'b0;
    set_load(5'd3); reg2_read_enabler = 1'b1; reg2_addr_output = 5'd3;
    step();
    idle(); ex_mc_start = 1'b1; ex_mc_len = 6'd5;
    step();
    idle();
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    n_vec++;
    if (stall_cycles !== want) begin n_err++; $display("FAIL stats_count: got %0d want %0d", stall_cycles, want); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (stall_cycles !== 32'd0) begin n_err++; $display("FAIL stats_clear: got %0d want 0", stall_cycles); end
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_multicycle();
    test_max_len();
    test_flush();
    test_proto_err();
    test_reset_mid_op();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
